// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;

   localparam logic [XLEN-1:0] DIV_ZERO_RES = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// 64-bit accumulator with a one-bit-per-cycle step: shift-add for multiply,
// restoring subtract for divide. Works on unsigned magnitudes only.
//   multiply: acc = {partial, multiplier}, shifts right
//   divide:   acc = {remainder, dividend/quotient}, shifts left
module muldiv_iter_core
   import muldiv_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_step,
   input  logic              i_is_div,
   input  logic [XLEN-1:0]   i_load_lo,
   input  logic [XLEN-1:0]   i_load_opnd,
   output logic [2*XLEN-1:0] o_acc_nxt
);

   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic              is_div_q, is_div_d;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic              rem_ge;
   logic [XLEN-1:0]   rem_diff;

   // Next accumulator value: load, one iteration, or hold.
   always_comb begin
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh   = acc_q[2*XLEN-1:XLEN-1];
      rem_ge   = (rem_sh >= {1'b0, opnd_q});
      // Remainder is always below the divisor, so the true difference fits in XLEN bits.
      rem_diff = rem_sh[XLEN-1:0] - opnd_q;
      if (i_load) begin
         acc_d    = {{XLEN{1'b0}}, i_load_lo};
         opnd_d   = i_load_opnd;
         is_div_d = i_is_div;
      end else if (i_step) begin
         if (is_div_q) begin
            acc_d = {(rem_ge ? rem_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
         end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
         end
      end
   end

   // Accumulator and operand registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
      end
   end

   assign o_acc_nxt = acc_d;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with register-file write-back.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for i_start; outputs quiet
//   ST_BUSY | 32 iterations of the shared accumulator, one per edge
//   ST_DONE | one cycle: o_done pulse and register-file write
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_rs1_dat,
   input  logic [XLEN-1:0] i_rs2_dat,
   input  logic [4:0]      i_rd_addr,
   input  logic            i_kill,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_wr_en,
   output logic [4:0]      o_wr_addr,
   output logic [XLEN-1:0] o_wr_dat
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   op_e               op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   res_q, res_d;

   op_e               op_in;
   logic              a_sgn, b_sgn, a_neg, b_neg, is_div_in;
   logic              div_zero, div_ovf, res_neg_in;
   logic [XLEN-1:0]   a_mag, b_mag, short_res;
   logic              core_load, core_step;
   logic [2*XLEN-1:0] acc_nxt, prod;
   logic [XLEN-1:0]   div_sel, post_res;

   assign op_in = op_e'(i_op);

   // Operand sign handling and the divide special cases, evaluated at accept.
   always_comb begin
      a_sgn      = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
      b_sgn      = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
      a_neg      = a_sgn & i_rs1_dat[XLEN-1];
      b_neg      = b_sgn & i_rs2_dat[XLEN-1];
      a_mag      = a_neg ? -i_rs1_dat : i_rs1_dat;
      b_mag      = b_neg ? -i_rs2_dat : i_rs2_dat;
      is_div_in  = i_op[2];
      // Remainder follows the dividend; quotient and product follow the xor.
      res_neg_in = (is_div_in && i_op[1]) ? a_neg : (a_neg ^ b_neg);
      div_zero   = is_div_in && (i_rs2_dat == '0);
      div_ovf    = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (i_rs1_dat == 32'h8000_0000) && (i_rs2_dat == '1);
      if (div_zero) begin
         short_res = i_op[1] ? i_rs1_dat : DIV_ZERO_RES;
      end else begin
         short_res = i_op[1] ? '0 : 32'h8000_0000;
      end
   end

   muldiv_iter_core u_core (
      .clk         (clk),
      .rst         (rst),
      .i_load      (core_load),
      .i_step      (core_step),
      .i_is_div    (is_div_in),
      .i_load_lo   (is_div_in ? a_mag : b_mag),
      .i_load_opnd (is_div_in ? b_mag : a_mag),
      .o_acc_nxt   (acc_nxt)
   );

   // Sign correction and half selection on the final accumulator value.
   always_comb begin
      prod    = neg_q ? -acc_nxt : acc_nxt;
      div_sel = op_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
      if (op_q[2]) begin
         post_res = neg_q ? -div_sel : div_sel;
      end else if (op_q == OP_MUL) begin
         post_res = prod[XLEN-1:0];
      end else begin
         post_res = prod[2*XLEN-1:XLEN];
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      rd_d      = rd_q;
      neg_d     = neg_q;
      res_d     = res_q;
      core_load = 1'b0;
      core_step = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start && !i_kill) begin
               op_d  = op_in;
               rd_d  = i_rd_addr;
               neg_d = res_neg_in;
               cnt_d = '0;
               if (div_zero || div_ovf) begin
                  res_d   = short_res;
                  state_d = ST_DONE;
               end else begin
                  core_load = 1'b1;
                  state_d   = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (i_kill) begin
               state_d = ST_IDLE;
            end else begin
               core_step = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  res_d   = post_res;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_MUL;
         rd_q    <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
      end
   end

   assign o_busy    = (state_q != ST_IDLE);
   assign o_done    = (state_q == ST_DONE);
   assign o_wr_en   = o_done && (rd_q != '0) && !i_kill;
   assign o_wr_addr = o_done ? rd_q : '0;
   assign o_wr_dat  = o_done ? res_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus kill/reset/x0 sequences.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_start = 1'b0;
   logic [2:0]  i_op = 3'd0;
   logic [31:0] i_rs1_dat = '0;
   logic [31:0] i_rs2_dat = '0;
   logic [4:0]  i_rd_addr = '0;
   logic        i_kill = 1'b0;
   logic        o_busy, o_done, o_wr_en;
   logic [4:0]  o_wr_addr;
   logic [31:0] o_wr_dat;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   muldiv_unit dut (
      .clk       (clk),
      .rst       (rst),
      .i_start   (i_start),
      .i_op      (i_op),
      .i_rs1_dat (i_rs1_dat),
      .i_rs2_dat (i_rs2_dat),
      .i_rd_addr (i_rd_addr),
      .i_kill    (i_kill),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_wr_en   (o_wr_en),
      .o_wr_addr (o_wr_addr),
      .o_wr_dat  (o_wr_dat)
   );

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request in cycle 0, then observe cycles 1..40.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int restart_at, input int kill_at,
                         output int done_cyc, output int n_done, output int n_wr,
                         output logic [31:0] dat, output logic [4:0] addr, output logic en,
                         output logic [63:0] busy_tr);
      done_cyc = -1; n_done = 0; n_wr = 0; dat = '0; addr = '0; en = 1'b0; busy_tr = '0;
      @(negedge clk);
      i_op = op; i_rs1_dat = a; i_rs2_dat = b; i_rd_addr = rd; i_start = 1'b1; i_kill = 1'b0;
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         i_start = (k == restart_at);
         i_kill  = (k == kill_at);
         #1;
         busy_tr[k] = o_busy;
         if (o_done) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = k; dat = o_wr_dat; addr = o_wr_addr; en = o_wr_en;
            end
         end
         if (o_wr_en) n_wr++;
         @(posedge clk); #1;
      end
      i_start = 1'b0;
      i_kill  = 1'b0;
   endtask

   initial begin
      int          dc, nd, nw;
      logic [31:0] dat;
      logic [4:0]  addr;
      logic        en;
      logic [63:0] btr;

      vecs.push_back('{"mul_7x6",      3'b000, 32'd7,        32'd6,        5'd5,  32'd42,       33});
      vecs.push_back('{"mul_m3x5",     3'b000, 32'hFFFFFFFD, 32'd5,        5'd6,  32'hFFFFFFF1, 33});
      vecs.push_back('{"mulh_min",     3'b001, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000, 33});
      vecs.push_back('{"mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, 33});
      vecs.push_back('{"mulhsu_max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'hFFFFFFFF, 33});
      vecs.push_back('{"div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33});
      vecs.push_back('{"rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33});
      vecs.push_back('{"div_100_m7",   3'b100, 32'd100,      32'hFFFFFFF9, 5'd12, 32'hFFFFFFF2, 33});
      vecs.push_back('{"rem_100_m7",   3'b110, 32'd100,      32'hFFFFFFF9, 5'd13, 32'd2,        33});
      vecs.push_back('{"divu_100_7",   3'b101, 32'd100,      32'd7,        5'd14, 32'd14,       33});
      vecs.push_back('{"remu_100_7",   3'b111, 32'd100,      32'd7,        5'd15, 32'd2,        33});
      vecs.push_back('{"divu_by0",     3'b101, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1});
      vecs.push_back('{"rem_by0",      3'b110, 32'd5,        32'd0,        5'd17, 32'd5,        1});
      vecs.push_back('{"div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1});
      vecs.push_back('{"rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        1});

      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {o_busy, o_done, o_wr_en, o_wr_addr, o_wr_dat}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_release_outputs", {o_busy, o_done, o_wr_en, o_wr_addr, o_wr_dat}, 64'd0);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, -1, -1, dc, nd, nw, dat, addr, en, btr);
         chk({vecs[i].name, "_done_cycle"}, dc, vecs[i].lat);
         chk({vecs[i].name, "_data"}, dat, vecs[i].exp);
         chk({vecs[i].name, "_wr_en"}, en, 1);
         chk({vecs[i].name, "_wr_addr"}, addr, vecs[i].rd);
         chk({vecs[i].name, "_done_count"}, nd, 1);
         chk({vecs[i].name, "_busy_c1"}, btr[1], 1);
      end

      // x0 destination with a stray start in the middle of the operation
      run_op(3'b000, 32'd3, 32'd3, 5'd0, 10, -1, dc, nd, nw, dat, addr, en, btr);
      chk("x0_done_cycle", dc, 33);
      chk("x0_done_count", nd, 1);
      chk("x0_wr_count", nw, 0);
      chk("x0_data", dat, 32'd9);

      // kill in BUSY
      run_op(3'b000, 32'd7, 32'd6, 5'd9, -1, 10, dc, nd, nw, dat, addr, en, btr);
      chk("kill_busy_c10", btr[10], 1);
      chk("kill_busy_c11", btr[11], 0);
      chk("kill_done_count", nd, 0);
      chk("kill_wr_count", nw, 0);

      // asynchronous reset between edges in cycle 5
      @(negedge clk);
      i_op = 3'b000; i_rs1_dat = 32'd5; i_rs2_dat = 32'd5; i_rd_addr = 5'd4; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_busy_before", o_busy, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_outputs", {o_busy, o_done, o_wr_en, o_wr_addr, o_wr_dat}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_idle_after", {o_busy, o_done, o_wr_en}, 64'd0);

      run_op(3'b000, 32'd2, 32'd2, 5'd3, -1, -1, dc, nd, nw, dat, addr, en, btr);
      chk("after_rst_done_cycle", dc, 33);
      chk("after_rst_data", dat, 32'd4);
      chk("after_rst_wr_en", en, 1);
      chk("after_rst_done_count", nd, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
